// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch resolution controller:
// B-type funct3 encodings, the controller state enum and the default datapath width.
package branch_ctrl_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVAL     = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } br_state_e;

endpackage

// File: rtl/branch_ctrl_if.sv
// Request channel into the branch controller: one branch/jump op per
// in_valid/in_ready handshake together with its operands.
//   master: issuing stage (drives op, samples in_ready)
//   slave : branch_ctrl  (samples op, drives in_ready)
interface branch_ctrl_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic            is_jal;
  logic            is_jalr;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  modport master (
    output in_valid, is_jal, is_jalr, funct3, pc, imm, rs1_data, rs2_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, is_jal, is_jalr, funct3, pc, imm, rs1_data, rs2_data,
    output in_ready
  );
endinterface

// File: rtl/branch_ctrl_cond_eval.sv
// Branch condition evaluator (purely combinational).
//   a_i, b_i   : registered operands
//   funct3_i   : B-type condition; funct3_i[1] selects unsigned compare
//   is_jump_i  : JAL/JALR, always taken, funct3 ignored
//   taken_o    : branch taken
//   illegal_o  : reserved B-type funct3 (010/011); forces not-taken
module branch_ctrl_cond_eval
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [2:0]      funct3_i,
  input  logic            is_jump_i,
  output logic            taken_o,
  output logic            illegal_o
);

  logic br_un;
  logic eq;
  logic lt;

  always_comb begin
    br_un     = funct3_i[1];
    eq        = (a_i == b_i);
    lt        = br_un ? (a_i < b_i) : ($signed(a_i) < $signed(b_i));
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    if (is_jump_i) begin
      taken_o = 1'b1;
    end else begin
      case (funct3_i)
        F3_BEQ:          taken_o = eq;
        F3_BNE:          taken_o = !eq;
        F3_BLT, F3_BLTU: taken_o = lt;
        F3_BGE, F3_BGEU: taken_o = !lt;
        default:         illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution sequencer for the execute stage.
//   clk, rst_n      : core clock, async active-low reset
//   req (slave)     : op handshake + operands, in_ready high only in IDLE
//   kill            : abandon the op in flight / block an accept
//   redirect_valid  : 1-cycle pulse, fetch loads redirect_pc
//   redirect_pc     : branch target
//   link_pc         : pc+4, valid with done
//   flush           : squash younger front-end ops, FLUSH_CYCLES wide
//   done            : 1-cycle pulse, op resolved
//   misalign        : 1-cycle pulse, taken target not word aligned
//   illegal         : 1-cycle pulse, reserved B-type funct3
//   branch_cnt      : resolved ops (wraps)
//   taken_cnt       : redirects issued (wraps)
//
// state    | meaning
// IDLE     | waiting for an op, in_ready=1
// EVAL     | compare registered operands, emit done/link, pick path
// REDIRECT | launch redirect + first flush cycle (visible next cycle)
// FLUSH    | hold flush for the remaining FLUSH_CYCLES-1 cycles
//
// All outputs are registered, so a state's effect shows one cycle later:
// done appears 2 cycles after accept, redirect_valid 3 cycles after accept.
// The final flush cycle overlaps IDLE, which is what gives a taken op an
// issue interval of FLUSH_CYCLES+2.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_ctrl_if.slave     req,
  input  logic             kill,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [XLEN-1:0]  link_pc,
  output logic             flush,
  output logic             done,
  output logic             misalign,
  output logic             illegal,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

  br_state_e        state_q, state_d;
  logic             is_jal_q, is_jalr_q;
  logic [2:0]       funct3_q;
  logic [XLEN-1:0]  pc_q, imm_q, rs1_q, rs2_q;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic             flush_q, flush_d;
  logic             done_q, done_d;
  logic             misalign_q, misalign_d;
  logic             illegal_q, illegal_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0]  link_pc_q, link_pc_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic             accept, taken, illegal_op;
  logic [XLEN-1:0]  target;

  assign req.in_ready = (state_q == IDLE);
  assign accept       = req.in_valid && req.in_ready && !kill;

  branch_ctrl_cond_eval #(.XLEN(XLEN)) u_cond (
    .a_i       (rs1_q),
    .b_i       (rs2_q),
    .funct3_i  (funct3_q),
    .is_jump_i (is_jal_q || is_jalr_q),
    .taken_o   (taken),
    .illegal_o (illegal_op)
  );

  // JALR drops bit0 before the alignment check on bit1.
  assign target = is_jalr_q ? ((rs1_q + imm_q) & {{(XLEN-1){1'b1}}, 1'b0})
                            : (pc_q + imm_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_jal_q  <= 1'b0;
      is_jalr_q <= 1'b0;
      funct3_q  <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else if (accept) begin
      is_jal_q  <= req.is_jal;
      is_jalr_q <= req.is_jalr;
      funct3_q  <= req.funct3;
      pc_q      <= req.pc;
      imm_q     <= req.imm;
      rs1_q     <= req.rs1_data;
      rs2_q     <= req.rs2_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      fcnt_q           <= '0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      done_q           <= 1'b0;
      misalign_q       <= 1'b0;
      illegal_q        <= 1'b0;
      redirect_pc_q    <= '0;
      link_pc_q        <= '0;
      branch_cnt_q     <= '0;
      taken_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      fcnt_q           <= fcnt_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
      done_q           <= done_d;
      misalign_q       <= misalign_d;
      illegal_q        <= illegal_d;
      redirect_pc_q    <= redirect_pc_d;
      link_pc_q        <= link_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      taken_cnt_q      <= taken_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    fcnt_d           = (fcnt_q != '0) ? fcnt_q - FCNT_W'(1) : '0;
    flush_d          = (fcnt_q != '0);
    redirect_valid_d = 1'b0;
    done_d           = 1'b0;
    misalign_d       = 1'b0;
    illegal_d        = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    link_pc_d        = link_pc_q;
    branch_cnt_d     = branch_cnt_q;
    taken_cnt_d      = taken_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) state_d = EVAL;
      end
      EVAL: begin
        done_d       = 1'b1;
        illegal_d    = illegal_op;
        link_pc_d    = pc_q + XLEN'(4);
        branch_cnt_d = branch_cnt_q + CNT_W'(1);
        state_d      = IDLE;
        if (taken) begin
          if (target[1]) begin
            misalign_d = 1'b1;
          end else begin
            redirect_pc_d = target;
            state_d       = REDIRECT;
          end
        end
      end
      REDIRECT: begin
        redirect_valid_d = 1'b1;
        flush_d          = 1'b1;
        fcnt_d           = FCNT_LOAD;
        taken_cnt_d      = taken_cnt_q + CNT_W'(1);
        state_d          = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
      end
      FLUSH: begin
        // Leave one cycle early: the last flush cycle is already registered.
        if (fcnt_q <= FCNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (kill) begin
      state_d          = IDLE;
      fcnt_d           = '0;
      flush_d          = 1'b0;
      redirect_valid_d = 1'b0;
      done_d           = 1'b0;
      misalign_d       = 1'b0;
      illegal_d        = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      link_pc_d        = link_pc_q;
      branch_cnt_d     = branch_cnt_q;
      taken_cnt_d      = taken_cnt_q;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign link_pc        = link_pc_q;
  assign flush          = flush_q;
  assign done           = done_q;
  assign misalign       = misalign_q;
  assign illegal        = illegal_q;
  assign branch_cnt     = branch_cnt_q;
  assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: stimulus pushes expected done/redirect
// events; a negedge monitor pops and compares when the DUT pulses them.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  localparam int XLEN  = 32;
  localparam int FC    = 2;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             kill = 1'b0;
  logic             redirect_valid, flush, done, misalign, illegal;
  logic [XLEN-1:0]  redirect_pc, link_pc;
  logic [CNT_W-1:0] branch_cnt, taken_cnt;

  branch_ctrl_if #(.XLEN(XLEN)) bif ();

  branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (bif),
    .kill           (kill),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .link_pc        (link_pc),
    .flush          (flush),
    .done           (done),
    .misalign       (misalign),
    .illegal        (illegal),
    .branch_cnt     (branch_cnt),
    .taken_cnt      (taken_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] link;
    logic        mis;
    logic        ill;
    logic [31:0] bcnt;
  } done_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [31:0] tcnt;
  } redir_t;

  done_t  dq[$];
  redir_t rq[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] bcnt_m   = '0;
  logic [31:0] tcnt_m   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (dq.size() == 0) fail_event("unexpected_done");
        else begin
          done_t e;
          e = dq.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("link_pc", link_pc, e.link);
          chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
          chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
          chk("branch_cnt", branch_cnt, e.bcnt);
        end
      end else begin
        if (misalign || illegal) fail_event("pulse_without_done");
        if (dq.size() > 0 && cyc > dq[0].cyc) begin
          fail_event("missing_done");
          void'(dq.pop_front());
        end
      end
      if (redirect_valid) begin
        if (rq.size() == 0) fail_event("unexpected_redirect");
        else begin
          redir_t r;
          r = rq.pop_front();
          chk("redirect_cycle", cyc, r.cyc);
          chk("redirect_pc", redirect_pc, r.pc);
          chk("taken_cnt", taken_cnt, r.tcnt);
          chk("flush_with_redirect", {31'd0, flush}, 32'd1);
        end
      end else if (rq.size() > 0 && cyc > rq[0].cyc) begin
        fail_event("missing_redirect");
        void'(rq.pop_front());
      end
    end
  end

  task automatic issue(input logic jal, input logic jalr, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic exp_done, input logic exp_redir,
                       input logic exp_mis, input logic exp_ill,
                       input logic [31:0] tgt, output int n);
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bif.in_ready && waited < 50);
    if (!bif.in_ready) fail_event("accept_timeout");
    bif.is_jal   = jal;
    bif.is_jalr  = jalr;
    bif.funct3   = f3;
    bif.pc       = pc;
    bif.imm      = imm;
    bif.rs1_data = a;
    bif.rs2_data = b;
    bif.in_valid = 1'b1;
    n = cyc;
    if (exp_done) begin
      bcnt_m = bcnt_m + 1;
      dq.push_back('{n + 2, pc + 32'd4, exp_mis, exp_ill, bcnt_m});
    end
    if (exp_redir) begin
      tcnt_m = tcnt_m + 1;
      rq.push_back('{n + 3, tgt, tcnt_m});
    end
    @(negedge clk);
    bif.in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, last_acc;
    bif.in_valid = 1'b0; bif.is_jal = 1'b0; bif.is_jalr = 1'b0; bif.funct3 = 3'b000;
    bif.pc = '0; bif.imm = '0; bif.rs1_data = '0; bif.rs2_data = '0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, bif.in_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_link_pc", link_pc, 32'd0);
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    chk("rst_taken_cnt", taken_cnt, 32'd0);
    wait_cycles(2);
    #1 rst_n = 1'b1;

    // BEQ taken, check flush shape
    issue(0, 0, F3_BEQ, 32'h100, 32'h20, 32'h1234, 32'h1234, 1, 1, 0, 0, 32'h120, n);
    @(negedge clk); chk("beq_flush_c2", {31'd0, flush}, 32'd0);
    chk("beq_ready_c2", {31'd0, bif.in_ready}, 32'd0);
    @(negedge clk); chk("beq_flush_c3", {31'd0, flush}, 32'd1);
    @(negedge clk); chk("beq_flush_c4", {31'd0, flush}, 32'd1);
    chk("beq_ready_c4", {31'd0, bif.in_ready}, 32'd1);
    @(negedge clk); chk("beq_flush_c5", {31'd0, flush}, 32'd0);
    chk("beq_taken_cnt", taken_cnt, 32'd1);

    // BLT signed -1 < 1 taken
    issue(0, 0, F3_BLT, 32'h200, 32'h40, 32'hFFFFFFFF, 32'h1, 1, 1, 0, 0, 32'h240, n);
    // BLTU same operands: not taken
    issue(0, 0, F3_BLTU, 32'h300, 32'h10, 32'hFFFFFFFF, 32'h1, 1, 0, 0, 0, 32'h0, n);
    @(negedge clk); chk("bltu_ready", {31'd0, bif.in_ready}, 32'd1);
    chk("bltu_flush", {31'd0, flush}, 32'd0);
    // JALR misaligned target 0x2002
    issue(0, 1, 3'b000, 32'h400, 32'h0, 32'h2003, 32'h0, 1, 0, 1, 0, 32'h0, n);
    wait_cycles(2);
    chk("jalr_taken_cnt", taken_cnt, tcnt_m);
    // Reserved funct3
    issue(0, 0, 3'b010, 32'h500, 32'h8, 32'h1, 32'h1, 1, 0, 0, 1, 32'h0, n);
    // JAL with pc wrap
    issue(1, 0, 3'b111, 32'hFFFFFFF0, 32'h20, 32'h0, 32'h0, 1, 1, 0, 0, 32'h10, n);
    // BNE taken with negative offset
    issue(0, 0, F3_BNE, 32'h600, 32'hFFFFFFF8, 32'h5, 32'h6, 1, 1, 0, 0, 32'h5F8, n);
    // BGE signed 1 >= -1 taken
    issue(0, 0, F3_BGE, 32'h700, 32'h8, 32'h1, 32'hFFFFFFFF, 1, 1, 0, 0, 32'h708, n);
    // BGEU 1 >= 0xFFFFFFFF not taken
    issue(0, 0, F3_BGEU, 32'h800, 32'h8, 32'h1, 32'hFFFFFFFF, 1, 0, 0, 0, 32'h0, n);

    // kill in REDIRECT cycle
    issue(0, 0, F3_BEQ, 32'h900, 32'h10, 32'h3, 32'h3, 1, 0, 0, 0, 32'h0, n);
    @(negedge clk); kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    chk("killred_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("killred_flush", {31'd0, flush}, 32'd0);
    chk("killred_ready", {31'd0, bif.in_ready}, 32'd1);
    chk("killred_taken_cnt", taken_cnt, tcnt_m);

    // kill in EVAL
    issue(0, 0, F3_BEQ, 32'h980, 32'h10, 32'h3, 32'h3, 0, 0, 0, 0, 32'h0, n);
    kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    chk("killeval_done", {31'd0, done}, 32'd0);
    chk("killeval_ready", {31'd0, bif.in_ready}, 32'd1);
    chk("killeval_branch_cnt", branch_cnt, bcnt_m);

    // kill in IDLE blocks accept
    bif.funct3 = F3_BEQ; bif.is_jal = 1'b0; bif.is_jalr = 1'b0;
    bif.rs1_data = 32'h1; bif.rs2_data = 32'h1; bif.pc = 32'h990;
    bif.in_valid = 1'b1; kill = 1'b1;
    @(negedge clk); bif.in_valid = 1'b0; kill = 1'b0;
    chk("killidle_ready", {31'd0, bif.in_ready}, 32'd1);
    wait_cycles(4);
    chk("killidle_branch_cnt", branch_cnt, bcnt_m);

    // back-to-back not-taken with in_valid held
    acc = 0; last_acc = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bif.funct3 = F3_BNE; bif.pc = 32'hA00; bif.imm = 32'h4;
        bif.rs1_data = 32'h7; bif.rs2_data = 32'h7; bif.in_valid = 1'b1;
      end
      if (bif.in_ready) begin
        n = cyc;
        if (last_acc >= 0) chk("b2b_spacing", n - last_acc, 32'd2);
        last_acc = n;
        acc++;
        bcnt_m = bcnt_m + 1;
        dq.push_back('{n + 2, 32'hA04, 1'b0, 1'b0, bcnt_m});
      end
    end
    @(negedge clk); bif.in_valid = 1'b0;
    chk("b2b_accepts", acc, 32'd4);
    wait_cycles(3);

    // reset during flush
    issue(0, 0, F3_BEQ, 32'hB00, 32'h100, 32'h9, 32'h9, 1, 1, 0, 0, 32'hC00, n);
    wait_cycles(2);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_flush", {31'd0, flush}, 32'd0);
    chk("rstmid_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rstmid_branch_cnt", branch_cnt, 32'd0);
    chk("rstmid_taken_cnt", taken_cnt, 32'd0);
    chk("rstmid_redirect_pc", redirect_pc, 32'd0);
    bcnt_m = '0; tcnt_m = '0;
    dq.delete(); rq.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    chk("rstmid_ready_after", {31'd0, bif.in_ready}, 32'd1);
    issue(0, 0, F3_BNE, 32'hC00, 32'h8, 32'h2, 32'h2, 1, 0, 0, 0, 32'h0, n);

    wait_cycles(8);
    chk("done_queue_empty", dq.size(), 32'd0);
    chk("redir_queue_empty", rq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
